yaki_router_nxm: RTL and testbench



---
 rtl/yaki_router_pkg.sv | 28 ++
 rtl/yaki_router_fifo.sv | 69 ++++++
 rtl/yaki_router_nxm.sv | 264 ++++++++++++++++++++++++++
 tb/tb_yaki_router_nxm.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yaki_router_pkg.sv
// Shared types and header-field helpers for the N x M wormhole packet router.
// Pure declarations: no logic, no latency, no flow control of its own.
package yaki_router_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      PARITY  = 2'd2,
      DROP    = 2'd3
   } in_state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_DEST   = 2'b01,
      ERR_PARITY = 2'b10
   } err_code_e;

   // Header layout, low bits first: {..., len[LEN_W], dest[ADDR_W]}
   function automatic logic [31:0] hdr_dest(input logic [31:0] hdr, input int addr_w);
      return hdr & ((32'd1 << addr_w) - 32'd1);
   endfunction

   function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int addr_w,
                                           input int len_w);
      return (hdr >> addr_w) & ((32'd1 << len_w) - 32'd1);
   endfunction

endpackage

// File: rtl/yaki_router_fifo.sv
// First-word-fall-through FIFO; a word written in cycle t is visible at t+1.
// Push while full is dropped (callers reserve space), pop while empty is ignored.
module yaki_router_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_push_dat,
   input  logic                         i_pop,
   output logic                         o_vld,
   output logic [W-1:0]                 o_dat,
   output logic [$clog2(DEPTH+1)-1:0]   o_free
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_pop   = i_pop && (count_q != '0);
      do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (do_push) begin
         mem_d[wr_ptr_q] = i_push_dat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count_q alone decides what is visible.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign o_vld  = (count_q != '0);
   assign o_dat  = o_vld ? mem_q[rd_ptr_q] : '0;
   assign o_free = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/yaki_router_nxm.sv
// N x M wormhole router: header word reaches its output FIFO one cycle after accept; no stall once granted.
// Headers wait for ownership, FIFO space and RR grant; YAKI_ROUTER_STATS_EN adds per-output packet counters.
module yaki_router_nxm
   import yaki_router_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int N_IN       = 2,
   parameter int N_OUT      = 4,
   parameter int LEN_W      = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_IN*DATA_W-1:0]    i_data,
   input  logic [N_IN-1:0]           i_vld,
   output logic [N_IN-1:0]           o_rdy,
   output logic [N_IN-1:0]           o_busy,
   output logic [N_OUT*DATA_W-1:0]   o_data,
   output logic [N_OUT-1:0]          o_vld,
   output logic [N_OUT-1:0]          o_last,
   input  logic [N_OUT-1:0]          i_rdy,
   output logic [N_IN-1:0]           o_err,
   output logic [N_IN*2-1:0]         o_err_code
`ifdef YAKI_ROUTER_STATS_EN
  ,output logic [N_OUT*16-1:0]       o_pkt_cnt
`endif
);

   localparam int ADDR_W = $clog2(N_OUT);
   localparam int IN_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int CNT_W  = LEN_W + 1;
   localparam int FC_W   = $clog2(FIFO_DEPTH + 1);

   logic [DATA_W-1:0] word   [N_IN];
   logic [ADDR_W-1:0] h_dest [N_IN];
   logic [LEN_W-1:0]  h_len  [N_IN];
   logic [N_IN-1:0]   h_bad;
   logic [N_IN-1:0]   hdr_ok;
   logic [N_IN-1:0]   acc;

   in_state_e         state_q [N_IN];
   in_state_e         state_d [N_IN];
   logic [CNT_W-1:0]  cnt_q   [N_IN];
   logic [CNT_W-1:0]  cnt_d   [N_IN];
   logic [ADDR_W-1:0] dest_q  [N_IN];
   logic [ADDR_W-1:0] dest_d  [N_IN];
   logic [DATA_W-1:0] par_q   [N_IN];
   logic [DATA_W-1:0] par_d   [N_IN];
   logic [N_IN-1:0]   err_q, err_d;
   err_code_e         code_q  [N_IN];
   err_code_e         code_d  [N_IN];

   logic [N_OUT-1:0]  owned_q, owned_d;
   logic [IN_W-1:0]   rr_q    [N_OUT];
   logic [IN_W-1:0]   rr_d    [N_OUT];
   logic [N_OUT-1:0]  gnt_vld;
   logic [IN_W-1:0]   gnt_idx [N_OUT];

   logic [N_OUT-1:0]  push_vld;
   logic [DATA_W:0]   push_dat [N_OUT];
   logic [DATA_W:0]   fifo_dat [N_OUT];
   logic [FC_W-1:0]   fifo_free [N_OUT];

   always_comb begin
      for (int k = 0; k < N_IN; k++) begin
         word[k]   = i_data[k*DATA_W +: DATA_W];
         h_dest[k] = ADDR_W'(hdr_dest(32'(word[k]), ADDR_W));
         h_len[k]  = LEN_W'(hdr_len(32'(word[k]), ADDR_W, LEN_W));
         h_bad[k]  = (int'(h_dest[k]) >= N_OUT);
      end
   end

   // Round-robin search per output, starting at the pointer, over IDLE inputs with a header for it.
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         gnt_vld[j] = 1'b0;
         gnt_idx[j] = '0;
         for (int i = 0; i < N_IN; i++) begin
            int idx;
            idx = (int'(rr_q[j]) + i) % N_IN;
            if (!gnt_vld[j] && (state_q[idx] == IDLE) && i_vld[idx] && !h_bad[idx] &&
                (int'(h_dest[idx]) == j)) begin
               gnt_vld[j] = 1'b1;
               gnt_idx[j] = IN_W'(idx);
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N_IN; k++) begin
         hdr_ok[k] = 1'b0;
         if (!i_rst && (state_q[k] == IDLE) && i_vld[k] && !h_bad[k]) begin
            hdr_ok[k] = !owned_q[h_dest[k]] &&
                        (int'(fifo_free[h_dest[k]]) >= int'(h_len[k]) + 1) &&
                        gnt_vld[h_dest[k]] && (int'(gnt_idx[h_dest[k]]) == k);
         end
         if (i_rst) begin
            o_rdy[k] = 1'b0;
         end else if (state_q[k] == IDLE) begin
            o_rdy[k] = hdr_ok[k] || (i_vld[k] && h_bad[k]);
         end else begin
            o_rdy[k] = 1'b1;
         end
         acc[k]        = i_vld[k] && o_rdy[k];
         o_busy[k]     = (state_q[k] != IDLE);
         o_err[k]      = err_q[k];
         o_err_code[2*k +: 2] = code_q[k];
      end
   end

   // Header and payload go to the FIFO; the parity word is only checked.
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         push_vld[j] = 1'b0;
         push_dat[j] = '0;
      end
      for (int k = 0; k < N_IN; k++) begin
         if (hdr_ok[k]) begin
            push_vld[h_dest[k]] = 1'b1;
            push_dat[h_dest[k]] = {(h_len[k] == '0), word[k]};
         end else if ((state_q[k] == PAYLOAD) && acc[k]) begin
            push_vld[dest_q[k]] = 1'b1;
            push_dat[dest_q[k]] = {(cnt_q[k] == CNT_W'(1)), word[k]};
         end
      end
   end

   always_comb begin
      owned_d = owned_q;
      for (int j = 0; j < N_OUT; j++) begin
         rr_d[j] = rr_q[j];
      end
      for (int k = 0; k < N_IN; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         dest_d[k]  = dest_q[k];
         par_d[k]   = par_q[k];
         err_d[k]   = 1'b0;
         code_d[k]  = ERR_NONE;
         case (state_q[k])
            IDLE: begin
               if (acc[k]) begin
                  par_d[k]  = word[k];
                  dest_d[k] = h_dest[k];
                  if (h_bad[k]) begin
                     state_d[k] = DROP;
                     cnt_d[k]   = CNT_W'(h_len[k]) + CNT_W'(1);
                     err_d[k]   = 1'b1;
                     code_d[k]  = ERR_DEST;
                  end else begin
                     owned_d[h_dest[k]] = 1'b1;
                     rr_d[h_dest[k]]    = IN_W'((k + 1) % N_IN);
                     cnt_d[k]           = CNT_W'(h_len[k]);
                     state_d[k]         = (h_len[k] == '0) ? PARITY : PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (acc[k]) begin
                  par_d[k] = par_q[k] ^ word[k];
                  cnt_d[k] = cnt_q[k] - CNT_W'(1);
                  if (cnt_q[k] == CNT_W'(1)) begin
                     state_d[k] = PARITY;
                  end
               end
            end
            PARITY: begin
               if (acc[k]) begin
                  state_d[k]         = IDLE;
                  owned_d[dest_q[k]] = 1'b0;
                  if (word[k] != par_q[k]) begin
                     err_d[k]  = 1'b1;
                     code_d[k] = ERR_PARITY;
                  end
               end
            end
            DROP: begin
               if (acc[k]) begin
                  cnt_d[k] = cnt_q[k] - CNT_W'(1);
                  if (cnt_q[k] == CNT_W'(1)) begin
                     state_d[k] = IDLE;
                  end
               end
            end
            default: state_d[k] = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         owned_q <= '0;
         err_q   <= '0;
         for (int j = 0; j < N_OUT; j++) begin
            rr_q[j] <= '0;
         end
         for (int k = 0; k < N_IN; k++) begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= '0;
            dest_q[k]  <= '0;
            par_q[k]   <= '0;
            code_q[k]  <= ERR_NONE;
         end
      end else begin
         owned_q <= owned_d;
         err_q   <= err_d;
         for (int j = 0; j < N_OUT; j++) begin
            rr_q[j] <= rr_d[j];
         end
         for (int k = 0; k < N_IN; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
            dest_q[k]  <= dest_d[k];
            par_q[k]   <= par_d[k];
            code_q[k]  <= code_d[k];
         end
      end
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      yaki_router_fifo #(
         .W     (DATA_W + 1),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_push     (push_vld[j]),
         .i_push_dat (push_dat[j]),
         .i_pop      (i_rdy[j]),
         .o_vld      (o_vld[j]),
         .o_dat      (fifo_dat[j]),
         .o_free     (fifo_free[j])
      );
      assign o_data[j*DATA_W +: DATA_W] = fifo_dat[j][DATA_W-1:0];
      assign o_last[j]                  = fifo_dat[j][DATA_W];
   end

`ifdef YAKI_ROUTER_STATS_EN
   logic [15:0] pkt_cnt_q [N_OUT];
   logic [15:0] pkt_cnt_d [N_OUT];

   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         pkt_cnt_d[j] = pkt_cnt_q[j];
         if (o_vld[j] && i_rdy[j] && o_last[j] && (pkt_cnt_q[j] != 16'hFFFF)) begin
            pkt_cnt_d[j] = pkt_cnt_q[j] + 16'd1;
         end
         o_pkt_cnt[j*16 +: 16] = pkt_cnt_q[j];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int j = 0; j < N_OUT; j++) begin
         if (i_rst) begin
            pkt_cnt_q[j] <= '0;
         end else begin
            pkt_cnt_q[j] <= pkt_cnt_d[j];
         end
      end
   end
`endif

endmodule

// File: tb/tb_yaki_router_nxm.sv
// Directed bench: default 2x4 router plus a 2x3 router for the bad-destination path.
module tb_yaki_router_nxm;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_data;
   logic [1:0]  i_vld;
   logic [1:0]  o_rdy, o_busy, o_err;
   logic [31:0] o_data;
   logic [3:0]  o_vld, o_last, i_rdy;
   logic [3:0]  o_err_code;

   logic [15:0] t_data;
   logic [1:0]  t_vld;
   logic [1:0]  t_o_rdy, t_busy, t_err;
   logic [23:0] t_o_data;
   logic [2:0]  t_o_vld, t_last, t_rdy;
   logic [3:0]  t_code;

`ifdef YAKI_ROUTER_STATS_EN
   logic [63:0] pkt_cnt;
   logic [47:0] t_pkt_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   yaki_router_nxm u_dut (
      .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy),
      .o_busy(o_busy), .o_data(o_data), .o_vld(o_vld), .o_last(o_last), .i_rdy(i_rdy),
      .o_err(o_err), .o_err_code(o_err_code)
`ifdef YAKI_ROUTER_STATS_EN
     ,.o_pkt_cnt(pkt_cnt)
`endif
   );

   yaki_router_nxm #(.N_OUT(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_data(t_data), .i_vld(t_vld), .o_rdy(t_o_rdy),
      .o_busy(t_busy), .o_data(t_o_data), .o_vld(t_o_vld), .o_last(t_last), .i_rdy(t_rdy),
      .o_err(t_err), .o_err_code(t_code)
`ifdef YAKI_ROUTER_STATS_EN
     ,.o_pkt_cnt(t_pkt_cnt)
`endif
   );

   typedef struct {
      logic [7:0]  d0;
      logic        v0;
      logic [7:0]  d1;
      logic        v1;
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_busy;
      logic [3:0]  exp_vld;
      logic [31:0] exp_data;
      logic [3:0]  exp_last;
      logic [1:0]  exp_err;
      logic [3:0]  exp_code;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [7:0] d0, input logic v0, input logic [7:0] d1,
                      input logic v1, input logic [1:0] erdy, input logic [1:0] ebusy,
                      input logic [3:0] evld, input logic [31:0] edata,
                      input logic [3:0] elast, input logic [1:0] eerr, input logic [3:0] ecode);
      vec_t v;
      v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1;
      v.exp_rdy = erdy; v.exp_busy = ebusy; v.exp_vld = evld; v.exp_data = edata;
      v.exp_last = elast; v.exp_err = eerr; v.exp_code = ecode;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_vld = '0;
      t_vld = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  par;
      logic [7:0]  exp_q[$];
      logic        exp_l[$];
      logic [31:0] mask;
      int          idx;

      i_data = '0; i_vld = '0; i_rdy = 4'hF;
      t_data = '0; t_vld = '0; t_rdy = 3'h7;

      // Reset state, with a valid header presented so o_rdy must be held low.
      rst = 1'b1;
      i_data = 16'h000E; i_vld = 2'b01;
      tick();
      tick();
      @(negedge clk);
      chk("rst_rdy", o_rdy, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_vld", o_vld, 0);
      chk("rst_last", o_last, 0);
      chk("rst_err", o_err, 0);
      chk("rst_code", o_err_code, 0);
      tick();
      rst = 1'b0;
      i_vld = '0;

      // Good packet to out2: header, 3 payload, parity.
      add(8'h0E,1, 8'h00,0, 2'b01,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);
      add(8'h11,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h0E << 16,  4'b0000, 2'b00, 4'h0);
      add(8'h22,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h11 << 16,  4'b0000, 2'b00, 4'h0);
      add(8'h33,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h22 << 16,  4'b0000, 2'b00, 4'h0);
      add(8'h0E,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h33 << 16,  4'b0100, 2'b00, 4'h0);
      add(8'h00,0, 8'h00,0, 2'b00,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);
      // Same packet with a bad parity word: delivered, then a one-cycle parity error.
      add(8'h0E,1, 8'h00,0, 2'b01,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);
      add(8'h11,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h0E << 16,  4'b0000, 2'b00, 4'h0);
      add(8'h22,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h11 << 16,  4'b0000, 2'b00, 4'h0);
      add(8'h33,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h22 << 16,  4'b0000, 2'b00, 4'h0);
      add(8'hFF,1, 8'h00,0, 2'b01,2'b01, 4'b0100, 32'h33 << 16,  4'b0100, 2'b00, 4'h0);
      add(8'h00,0, 8'h00,0, 2'b00,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b01, 4'b0010);
      add(8'h00,0, 8'h00,0, 2'b00,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);
      // Both inputs to out1 together: in0 wins, in1 waits for parity release.
      add(8'h05,1, 8'h05,1, 2'b01,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);
      add(8'hA0,1, 8'h05,1, 2'b01,2'b01, 4'b0010, 32'h05 << 8,   4'b0000, 2'b00, 4'h0);
      add(8'hA5,1, 8'h05,1, 2'b01,2'b01, 4'b0010, 32'hA0 << 8,   4'b0010, 2'b00, 4'h0);
      add(8'h00,0, 8'h05,1, 2'b10,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);
      add(8'h00,0, 8'hB0,1, 2'b10,2'b10, 4'b0010, 32'h05 << 8,   4'b0000, 2'b00, 4'h0);
      add(8'h00,0, 8'hB5,1, 2'b10,2'b10, 4'b0010, 32'hB0 << 8,   4'b0010, 2'b00, 4'h0);
      add(8'h00,0, 8'h00,0, 2'b00,2'b00, 4'b0000, 32'h0,         4'b0000, 2'b00, 4'h0);

      for (int n = 0; n < vecs.size(); n++) begin
         i_data = {vecs[n].d1, vecs[n].d0};
         i_vld  = {vecs[n].v1, vecs[n].v0};
         @(negedge clk);
         mask = '0;
         for (int j = 0; j < 4; j++) begin
            if (vecs[n].exp_vld[j]) mask[j*8 +: 8] = 8'hFF;
         end
         chk($sformatf("v%0d_rdy", n), o_rdy, vecs[n].exp_rdy);
         chk($sformatf("v%0d_busy", n), o_busy, vecs[n].exp_busy);
         chk($sformatf("v%0d_vld", n), o_vld, vecs[n].exp_vld);
         chk($sformatf("v%0d_data", n), o_data & mask, vecs[n].exp_data);
         chk($sformatf("v%0d_last", n), o_last, vecs[n].exp_last);
         chk($sformatf("v%0d_err", n), o_err, vecs[n].exp_err);
         chk($sformatf("v%0d_code", n), o_err_code, vecs[n].exp_code);
         tick();
      end
      i_vld = '0;

      // Fill out3 completely with a 16-word packet, then a len-0 header must wait for one pop.
      do_reset();
      i_rdy = 4'b0111;
      i_data = 16'h003F; i_vld = 2'b01;
      @(negedge clk);
      chk("full_hdr_rdy", o_rdy[0], 1);
      tick();
      par = 8'h3F;
      for (int p = 1; p <= 15; p++) begin
         i_data = 16'(p);
         par ^= 8'(p);
         exp_q.push_back(8'(p));
         exp_l.push_back(p == 15);
         tick();
      end
      i_data = {8'h00, par};
      tick();
      i_data = 16'h0003;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("stall_rdy%0d", c), o_rdy[0], 0);
         tick();
      end
      @(negedge clk);
      chk("stall_head_dat", o_data[31:24], 8'h3F);
      i_rdy = 4'b1111;
      chk("stall_pop_rdy", o_rdy[0], 0);
      tick();
      i_rdy = 4'b0111;
      @(negedge clk);
      chk("resume_rdy", o_rdy[0], 1);
      tick();
      i_data = 16'h0003;
      @(negedge clk);
      chk("resume_par_rdy", o_rdy[0], 1);
      tick();
      i_vld = '0;
      exp_q.push_back(8'h03);
      exp_l.push_back(1'b1);
      i_rdy = 4'b1111;
      idx = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_vld[3] && idx < exp_q.size()) begin
            chk($sformatf("drain_dat%0d", idx), o_data[31:24], exp_q[idx]);
            chk($sformatf("drain_last%0d", idx), o_last[3], exp_l[idx]);
            idx++;
         end
         tick();
      end
      chk("drain_cnt", idx, 16);

      // 2x3 router: dest 3 is invalid, packet is absorbed with an error pulse.
      do_reset();
      t_rdy = 3'b111;
      t_data = 16'h000B; t_vld = 2'b01;
      @(negedge clk);
      chk("bad_hdr_rdy", t_o_rdy[0], 1);
      tick();
      for (int w = 1; w <= 3; w++) begin
         t_data = 16'(w);
         @(negedge clk);
         chk($sformatf("bad_rdy%0d", w), t_o_rdy[0], 1);
         chk($sformatf("bad_busy%0d", w), t_busy[0], 1);
         chk($sformatf("bad_vld%0d", w), t_o_vld, 0);
         chk($sformatf("bad_err%0d", w), t_err, (w == 1) ? 2'b01 : 2'b00);
         chk($sformatf("bad_code%0d", w), t_code, (w == 1) ? 4'b0001 : 4'b0000);
         tick();
      end
      t_vld = '0;
      @(negedge clk);
      chk("bad_done_busy", t_busy, 0);
      chk("bad_done_vld", t_o_vld, 0);
      tick();

      // Reset in the middle of a packet with words parked in the FIFO.
      t_rdy = 3'b000;
      t_data = 16'h0008; t_vld = 2'b01;
      tick();
      t_data = 16'h0055;
      @(negedge clk);
      chk("mid_pre_vld", t_o_vld, 3'b001);
      tick();
      rst = 1'b1;
      t_vld = '0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_vld", t_o_vld, 0);
      chk("mid_rst_busy", t_busy, 0);
      chk("mid_rst_rdy", t_o_rdy, 0);
      chk("mid_rst_data", t_o_data, 0);
      chk("mid_rst_last", t_last, 0);
      chk("mid_rst_err", t_err, 0);
      tick();
      t_rdy = 3'b111;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("mid_empty%0d", c), t_o_vld, 0);
         tick();
      end

`ifdef YAKI_ROUTER_STATS_EN
      do_reset();
      i_rdy = 4'hF;
      i_data = 16'h0000; i_vld = 2'b01;
      for (int c = 0; c < 6; c++) tick();
      i_vld = '0;
      for (int c = 0; c < 4; c++) tick();
      @(negedge clk);
      chk("stats_out0", pkt_cnt[15:0], 16'd3);
      chk("stats_out1", pkt_cnt[31:16], 16'd0);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
